i2c_reg_ctrl: RTL and testbench



---
 rtl/i2c_reg_pkg.sv | 23 ++
 rtl/i2c_reg_ctrl_reg_ptr.sv | 44 ++++
 rtl/i2c_reg_ctrl.sv | 184 ++++++++++++++++++
 tb/tb_i2c_reg_ctrl.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/i2c_reg_pkg.sv
// Shared types and default sizes for the I2C-to-LED-register sequencer.
package i2c_reg_pkg;

    localparam int unsigned I2C_ADDR_W   = 3;
    localparam int unsigned I2C_DATA_W   = 8;
    localparam int unsigned I2C_NUM_REGS = 8;
    localparam int unsigned I2C_AI_BIT   = 7;
    localparam int unsigned ERR_CNT_W    = 8;

    // LED register map indices
    localparam int unsigned MODE         = 0;
    localparam int unsigned SLEEP_BIT    = 4;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CTRL,
        ST_WR_DATA,
        ST_RD_IDLE,
        ST_RD_FETCH,
        ST_RD_PRESENT
    } i2c_reg_state_t;

endpackage

// File: rtl/i2c_reg_ctrl_reg_ptr.sv
// Register pointer with auto-increment flag: load from the control byte,
// optional increment with wrap from NUM_REGS-1 back to 0.
module reg_ptr #(
    parameter int unsigned ADDR_W   = 3,
    parameter int unsigned NUM_REGS = 8
) (
    input  logic              clk_osc,
    input  logic              reset,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_ptr_i,
    input  logic              load_ai_i,
    input  logic              incr_i,
    output logic [ADDR_W-1:0] ptr_o,
    output logic              ai_o
);

    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic              ai_q, ai_d;

    always_comb begin
        ptr_d = ptr_q;
        ai_d  = ai_q;
        if (load_i) begin
            ptr_d = load_ptr_i;
            ai_d  = load_ai_i;
        end else if (incr_i && ai_q) begin
            ptr_d = (ptr_q == ADDR_W'(NUM_REGS - 1)) ? '0 : ptr_q + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk_osc) begin
        if (reset) begin
            ptr_q <= '0;
            ai_q  <= 1'b0;
        end else begin
            ptr_q <= ptr_d;
            ai_q  <= ai_d;
        end
    end

    assign ptr_o = ptr_q;
    assign ai_o  = ai_q;

endmodule

// File: rtl/i2c_reg_ctrl.sv
// Turns the I2C byte stream into single-cycle register write/read strobes.
// Define I2C_ERR_CNT_EN to build the saturating protocol error counter.
module i2c_reg_ctrl
    import i2c_reg_pkg::*;
#(
    parameter int unsigned ADDR_W   = I2C_ADDR_W,
    parameter int unsigned DATA_W   = I2C_DATA_W,
    parameter int unsigned NUM_REGS = I2C_NUM_REGS,
    parameter int unsigned AI_BIT   = I2C_AI_BIT
) (
    input  logic                 clk_osc,
    input  logic                 reset,
    input  logic                 txn_start,
    input  logic                 txn_read,
    input  logic                 txn_stop,
    input  logic [DATA_W-1:0]    i2c_byte,
    input  logic                 i2c_byte_valid,
    input  logic                 tx_req,
    output logic [DATA_W-1:0]    tx_byte,
    output logic                 tx_valid,
    output logic [ADDR_W-1:0]    reg_addr,
    output logic [DATA_W-1:0]    reg_wdata,
    output logic                 reg_write,
    output logic                 reg_read,
    input  logic [DATA_W-1:0]    reg_rdata,
    output logic                 busy,
    output logic [ERR_CNT_W-1:0] err_count
);

    i2c_reg_state_t    state_q, state_d;
    logic              stop_pend_q, stop_pend_d;
    logic              reg_write_q, reg_write_d;
    logic              reg_read_q, reg_read_d;
    logic [ADDR_W-1:0] reg_addr_q, reg_addr_d;
    logic [DATA_W-1:0] reg_wdata_q, reg_wdata_d;
    logic              tx_valid_q, tx_valid_d;
    logic [DATA_W-1:0] tx_byte_q, tx_byte_d;
    logic              busy_q;

    logic              ptr_load_c;
    logic [ADDR_W-1:0] ptr_load_val_c;
    logic              ptr_load_ai_c;
    logic              ptr_incr_c;
    logic [ADDR_W-1:0] ptr;
    logic              ai;
    logic              ctrl_oor_c;

    // Address field is every bit below the auto-increment flag
    assign ctrl_oor_c = (32'(i2c_byte[AI_BIT-1:0]) >= NUM_REGS);

    reg_ptr #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_reg_ptr (
        .clk_osc    (clk_osc),
        .reset      (reset),
        .load_i     (ptr_load_c),
        .load_ptr_i (ptr_load_val_c),
        .load_ai_i  (ptr_load_ai_c),
        .incr_i     (ptr_incr_c),
        .ptr_o      (ptr),
        .ai_o       (ai)
    );

    always_comb begin
        state_d        = state_q;
        stop_pend_d    = stop_pend_q;
        reg_write_d    = 1'b0;
        reg_read_d     = 1'b0;
        reg_addr_d     = reg_addr_q;
        reg_wdata_d    = reg_wdata_q;
        tx_valid_d     = 1'b0;
        tx_byte_d      = tx_valid_q ? reg_rdata : tx_byte_q;
        ptr_load_c     = 1'b0;
        ptr_load_val_c = '0;
        ptr_load_ai_c  = 1'b0;
        ptr_incr_c     = 1'b0;

        unique case (state_q)
            ST_IDLE: ;
            ST_CTRL: begin
                if (i2c_byte_valid) begin
                    ptr_load_c     = 1'b1;
                    ptr_load_val_c = ctrl_oor_c ? '0 : i2c_byte[ADDR_W-1:0];
                    ptr_load_ai_c  = i2c_byte[AI_BIT];
                    state_d        = txn_stop ? ST_IDLE : ST_WR_DATA;
                end else if (txn_stop) begin
                    state_d = ST_IDLE;
                end
            end
            ST_WR_DATA: begin
                if (i2c_byte_valid) begin
                    reg_write_d = 1'b1;
                    reg_addr_d  = ptr;
                    reg_wdata_d = i2c_byte;
                    ptr_incr_c  = 1'b1;
                end
                if (txn_stop) state_d = ST_IDLE;
            end
            ST_RD_IDLE: begin
                if (tx_req) begin
                    reg_read_d  = 1'b1;
                    reg_addr_d  = ptr;
                    stop_pend_d = txn_stop;
                    state_d     = ST_RD_FETCH;
                end else if (txn_stop) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RD_FETCH: begin
                tx_valid_d = 1'b1;
                if (txn_stop) stop_pend_d = 1'b1;
                state_d = ST_RD_PRESENT;
            end
            ST_RD_PRESENT: begin
                ptr_incr_c  = 1'b1;
                stop_pend_d = 1'b0;
                state_d     = (txn_stop || stop_pend_q) ? ST_IDLE : ST_RD_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase

        // A (repeated) START redirects from any state; pointer and ai survive
        if (txn_start) begin
            state_d     = txn_read ? ST_RD_IDLE : ST_CTRL;
            stop_pend_d = 1'b0;
        end
    end

    always_ff @(posedge clk_osc) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            stop_pend_q <= 1'b0;
            reg_write_q <= 1'b0;
            reg_read_q  <= 1'b0;
            reg_addr_q  <= '0;
            reg_wdata_q <= '0;
            tx_valid_q  <= 1'b0;
            tx_byte_q   <= '0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            stop_pend_q <= stop_pend_d;
            reg_write_q <= reg_write_d;
            reg_read_q  <= reg_read_d;
            reg_addr_q  <= reg_addr_d;
            reg_wdata_q <= reg_wdata_d;
            tx_valid_q  <= tx_valid_d;
            tx_byte_q   <= tx_byte_d;
            busy_q      <= (state_d != ST_IDLE);
        end
    end

    // Strobes already in flight are suppressed while reset is asserted
    assign reg_write = reg_write_q & ~reset;
    assign reg_read  = reg_read_q & ~reset;
    assign tx_valid  = tx_valid_q & ~reset;
    assign tx_byte   = tx_valid_q ? reg_rdata : tx_byte_q;
    assign reg_addr  = reg_addr_q;
    assign reg_wdata = reg_wdata_q;
    assign busy      = busy_q;

`ifdef I2C_ERR_CNT_EN
    logic                 err_c;
    logic [ERR_CNT_W-1:0] err_cnt_q;

    assign err_c = (i2c_byte_valid && (state_q inside {ST_IDLE, ST_RD_IDLE, ST_RD_FETCH, ST_RD_PRESENT}))
                || (tx_req && (state_q != ST_RD_IDLE))
                || (i2c_byte_valid && (state_q == ST_CTRL) && ctrl_oor_c);

    always_ff @(posedge clk_osc) begin
        if (reset) begin
            err_cnt_q <= '0;
        end else if (err_c && (err_cnt_q != '1)) begin
            err_cnt_q <= err_cnt_q + ERR_CNT_W'(1);
        end
    end

    assign err_count = err_cnt_q;
`else
    assign err_count = '0;
`endif

endmodule

// File: tb/tb_i2c_reg_ctrl.sv
// Self-checking bench for i2c_reg_ctrl: table-driven write transactions,
// scoreboard of expected register strobes, and hand-written corner sequences.
module tb_i2c_reg_ctrl;

    logic       clk_osc = 1'b0;
    logic       reset = 1'b1;
    logic       txn_start = 1'b0;
    logic       txn_read = 1'b0;
    logic       txn_stop = 1'b0;
    logic [7:0] i2c_byte = '0;
    logic       i2c_byte_valid = 1'b0;
    logic       tx_req = 1'b0;
    logic [7:0] tx_byte;
    logic       tx_valid;
    logic [2:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_write;
    logic       reg_read;
    logic [7:0] reg_rdata = '0;
    logic       busy;
    logic [7:0] err_count;

    i2c_reg_ctrl dut (
        .clk_osc        (clk_osc),
        .reset          (reset),
        .txn_start      (txn_start),
        .txn_read       (txn_read),
        .txn_stop       (txn_stop),
        .i2c_byte       (i2c_byte),
        .i2c_byte_valid (i2c_byte_valid),
        .tx_req         (tx_req),
        .tx_byte        (tx_byte),
        .tx_valid       (tx_valid),
        .reg_addr       (reg_addr),
        .reg_wdata      (reg_wdata),
        .reg_write      (reg_write),
        .reg_read       (reg_read),
        .reg_rdata      (reg_rdata),
        .busy           (busy),
        .err_count      (err_count)
    );

    always #5 clk_osc = ~clk_osc;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int rd_cnt = 0;
    int rd_k = 0;
    int exp_err = 0;
    logic [7:0] last_tx = '0;

    always @(posedge clk_osc) cyc <= cyc + 1;

    typedef struct { logic [2:0] addr; logic [7:0] data; } wr_exp_t;
    typedef struct { logic [2:0] addr; logic [7:0] data; int cyc; } rd_exp_t;
    wr_exp_t wq[$];
    rd_exp_t rq[$];

    typedef struct {
        logic [7:0]      ctrl;
        int              n;
        logic [2:0][7:0] d;
        logic [2:0][2:0] a;
        logic            stop_last;
        logic [2:0]      ptr_after;
        int              err_inc;
    } vec_t;

    function automatic logic [7:0] rd_pattern(input logic [2:0] a, input int k);
        return 8'h3C ^ 8'(a) ^ 8'(k * 17);
    endfunction

    function automatic logic [7:0] exp_errcnt(input int n);
`ifdef I2C_ERR_CNT_EN
        return (n > 255) ? 8'hFF : 8'(n);
`else
        return 8'h00;
`endif
    endfunction

    function automatic vec_t mk(input logic [7:0] ctrl, input int n,
                                input logic [7:0] d0, input logic [7:0] d1, input logic [7:0] d2,
                                input logic [2:0] a0, input logic [2:0] a1, input logic [2:0] a2,
                                input logic sl, input logic [2:0] pa, input int ei);
        vec_t v;
        v.ctrl = ctrl; v.n = n;
        v.d[0] = d0; v.d[1] = d1; v.d[2] = d2;
        v.a[0] = a0; v.a[1] = a1; v.a[2] = a2;
        v.stop_last = sl; v.ptr_after = pa; v.err_inc = ei;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Register file model: read data appears the cycle after reg_read
    always @(posedge clk_osc) begin
        if (reg_read) begin
            reg_rdata <= rd_pattern(reg_addr, rd_cnt);
            rd_cnt    <= rd_cnt + 1;
        end
    end

    // Scoreboard: every strobe must match the head of its expectation queue
    always @(negedge clk_osc) begin
        if (reg_write) begin
            check("wr_rd_overlap", 32'(reg_read), 32'h0);
            if (wq.size() == 0) begin
                check("unexpected_write", 32'(reg_write), 32'h0);
            end else begin
                wr_exp_t e;
                e = wq.pop_front();
                check("write_addr", 32'(reg_addr), 32'(e.addr));
                check("write_data", 32'(reg_wdata), 32'(e.data));
            end
        end
        if (reg_read) begin
            if (rq.size() == 0) begin
                check("unexpected_read", 32'(reg_read), 32'h0);
            end else begin
                check("read_addr", 32'(reg_addr), 32'(rq[0].addr));
                check("read_latency", 32'(cyc - rq[0].cyc), 32'd1);
            end
        end
        if (tx_valid) begin
            if (rq.size() == 0) begin
                check("unexpected_tx_valid", 32'(tx_valid), 32'h0);
            end else begin
                rd_exp_t e;
                e = rq.pop_front();
                check("tx_byte", 32'(tx_byte), 32'(e.data));
                check("tx_latency", 32'(cyc - e.cyc), 32'd2);
                last_tx = e.data;
            end
        end
    end

    task automatic tick();
        @(posedge clk_osc);
        #1;
    endtask

    task automatic cyc_drive(input logic st, input logic rd, input logic sp,
                             input logic bv, input logic [7:0] b, input logic tr);
        txn_start = st; txn_read = rd; txn_stop = sp;
        i2c_byte_valid = bv; i2c_byte = b; tx_req = tr;
        tick();
        txn_start = 1'b0; txn_stop = 1'b0; i2c_byte_valid = 1'b0; tx_req = 1'b0;
    endtask

    task automatic read_req(input logic [2:0] exp_addr);
        rd_exp_t e;
        e.addr = exp_addr;
        e.data = rd_pattern(exp_addr, rd_k);
        e.cyc  = cyc;
        rd_k++;
        rq.push_back(e);
        cyc_drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        repeat (3) tick();
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_reg_write"}, 32'(reg_write), 32'h0);
        check({tag, "_reg_read"},  32'(reg_read),  32'h0);
        check({tag, "_tx_valid"},  32'(tx_valid),  32'h0);
        check({tag, "_tx_byte"},   32'(tx_byte),   32'h0);
        check({tag, "_reg_addr"},  32'(reg_addr),  32'h0);
        check({tag, "_reg_wdata"}, 32'(reg_wdata), 32'h0);
        check({tag, "_busy"},      32'(busy),      32'h0);
        check({tag, "_err_count"}, 32'(err_count), 32'h0);
    endtask

    vec_t vecs[5];

    initial begin
        vecs[0] = mk(8'h82, 2, 8'hAA, 8'h55, 8'h00, 3'd2, 3'd3, 3'd0, 1'b0, 3'd4, 0);
        vecs[1] = mk(8'h87, 3, 8'h11, 8'h22, 8'h33, 3'd7, 3'd0, 3'd1, 1'b1, 3'd2, 0);
        vecs[2] = mk(8'h05, 2, 8'h44, 8'h66, 8'h00, 3'd5, 3'd5, 3'd0, 1'b0, 3'd5, 0);
        vecs[3] = mk(8'h90, 2, 8'h77, 8'h88, 8'h00, 3'd0, 3'd1, 3'd0, 1'b1, 3'd2, 1);
        vecs[4] = mk(8'h0B, 1, 8'h5A, 8'h00, 8'h00, 3'd0, 3'd0, 3'd0, 1'b0, 3'd0, 1);

        // Reset state
        tick(); tick();
        @(negedge clk_osc);
        check_all_zero("reset");
        reset = 1'b0;
        tick();

        // Write transactions, each followed by a read that exposes the pointer
        for (int i = 0; i < 5; i++) begin
            vec_t v;
            v = vecs[i];
            cyc_drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
            cyc_drive(1'b0, 1'b0, 1'b0, 1'b1, v.ctrl, 1'b0);
            exp_err += v.err_inc;
            for (int j = 0; j < v.n; j++) begin
                wq.push_back('{addr: v.a[j], data: v.d[j]});
                cyc_drive(1'b0, 1'b0, v.stop_last && (j == v.n - 1), 1'b1, v.d[j], 1'b0);
            end
            if (!v.stop_last) cyc_drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
            @(negedge clk_osc);
            check($sformatf("vec%0d_busy_after_stop", i), 32'(busy), 32'h0);
            check($sformatf("vec%0d_err_count", i), 32'(err_count), 32'(exp_errcnt(exp_err)));
            cyc_drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
            read_req(v.ptr_after);
            cyc_drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        end

        // Pointer write then repeated-start read, ai=0: both reads hit addr 7
        cyc_drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc_drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h07, 1'b0);
        cyc_drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        @(negedge clk_osc);
        check("rd_busy", 32'(busy), 32'h1);
        read_req(3'd7);
        read_req(3'd7);
        repeat (2) tick();
        @(negedge clk_osc);
        check("tx_byte_hold", 32'(tx_byte), 32'(last_tx));
        cyc_drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Reset the cycle after a data byte: the pending write is dropped
        cyc_drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc_drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h83, 1'b0);
        cyc_drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h99, 1'b0);
        reset = 1'b1;
        @(negedge clk_osc);
        check("rst_drop_write", 32'(reg_write), 32'h0);
        tick();
        @(negedge clk_osc);
        check_all_zero("midrst");
        reset = 1'b0;
        exp_err = 0;
        tick();
        cyc_drive(1'b1, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        read_req(3'd0);
        read_req(3'd0);
        cyc_drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);

        // Protocol errors: byte in IDLE, tx_req during a write
        cyc_drive(1'b0, 1'b0, 1'b0, 1'b1, 8'hEE, 1'b0);
        exp_err++;
        cyc_drive(1'b1, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0);
        cyc_drive(1'b0, 1'b0, 1'b0, 1'b1, 8'h01, 1'b0);
        cyc_drive(1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1);
        exp_err++;
        cyc_drive(1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0);
        @(negedge clk_osc);
        check("err_count_two", 32'(err_count), 32'(exp_errcnt(exp_err)));

        // Saturation after 300 more error cycles
        for (int k = 0; k < 300; k++) begin
            cyc_drive(1'b0, 1'b0, 1'b0, 1'b1, 8'(k), 1'b0);
            exp_err++;
        end
        @(negedge clk_osc);
        check("err_count_sat", 32'(err_count), 32'(exp_errcnt(exp_err)));

        repeat (3) tick();
        check("writes_outstanding", 32'(wq.size()), 32'h0);
        check("reads_outstanding", 32'(rq.size()), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
